// File: rtl/apb_master_ctrl.sv
// apb_master_ctrl
// ---------------------------------------------------------------------------
// APB3 initiator. It takes one request at a time from a valid/ready command
// port and runs the matching SETUP/ACCESS transfer. It then holds the result
// on a valid/ready response port until the consumer takes it.
// A saturating wait-state counter aborts an ACCESS phase that never sees
// PREADY, so a dead responder cannot hang the bus.
//
// Ports
//   PCLK, PRESETn          clock (rising edge), async active-low reset
//   req_valid/req_ready    request handshake (req_ready decoded from state)
//   req_write/addr/wdata   request payload, latched on acceptance
//   rsp_valid/rsp_ready    response handshake
//   rsp_rdata/err/timeout  response payload, held until the next capture
//   PADDR..PWDATA          APB initiator outputs (all registered)
//   PREADY/PRDATA/PSLVERR  APB responder inputs
//
// Parameters
//   ADDR_W, DATA_W  bus widths
//   TIMEOUT         wait states tolerated before abort (0 = never abort)
// ---------------------------------------------------------------------------
module apb_master_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] PADDR,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [DATA_W-1:0] PWDATA,
  input  logic              PREADY,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PSLVERR
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] paddr_reg, paddr_next;
  logic [DATA_W-1:0] pwdata_reg, pwdata_next;
  logic              pwrite_reg, pwrite_next;
  logic              psel_reg, psel_next;
  logic              penable_reg, penable_next;
  logic              rsp_valid_reg, rsp_valid_next;
  logic [DATA_W-1:0] rsp_rdata_reg, rsp_rdata_next;
  logic              rsp_err_reg, rsp_err_next;
  logic              rsp_timeout_reg, rsp_timeout_next;
  logic [CNT_W-1:0]  wait_cnt_reg, wait_cnt_next;
  logic              timeout_hit;

  // The abort fires only once the counter has already absorbed TIMEOUT wait
  // states, so a responder that needs exactly TIMEOUT wait states still
  // finishes normally on the following cycle.
  assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_reg == TIMEOUT_CNT);

  // State and output registers
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_reg       <= ST_IDLE;
      paddr_reg       <= '0;
      pwdata_reg      <= '0;
      pwrite_reg      <= 1'b0;
      psel_reg        <= 1'b0;
      penable_reg     <= 1'b0;
      rsp_valid_reg   <= 1'b0;
      rsp_rdata_reg   <= '0;
      rsp_err_reg     <= 1'b0;
      rsp_timeout_reg <= 1'b0;
      wait_cnt_reg    <= '0;
    end else begin
      state_reg       <= state_next;
      paddr_reg       <= paddr_next;
      pwdata_reg      <= pwdata_next;
      pwrite_reg      <= pwrite_next;
      psel_reg        <= psel_next;
      penable_reg     <= penable_next;
      rsp_valid_reg   <= rsp_valid_next;
      rsp_rdata_reg   <= rsp_rdata_next;
      rsp_err_reg     <= rsp_err_next;
      rsp_timeout_reg <= rsp_timeout_next;
      wait_cnt_reg    <= wait_cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (req_valid) state_next = ST_SETUP;
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_next = ST_RESP;
      ST_RESP:   if (rsp_ready) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs. The APB strobes change on the
  // same edge as the state, so they stay aligned with it.
  always_comb begin
    paddr_next       = paddr_reg;
    pwdata_next      = pwdata_reg;
    pwrite_next      = pwrite_reg;
    psel_next        = psel_reg;
    penable_next     = penable_reg;
    rsp_valid_next   = rsp_valid_reg;
    rsp_rdata_next   = rsp_rdata_reg;
    rsp_err_next     = rsp_err_reg;
    rsp_timeout_next = rsp_timeout_reg;
    wait_cnt_next    = wait_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (req_valid) begin
          paddr_next    = req_addr;
          pwdata_next   = req_wdata;
          pwrite_next   = req_write;
          psel_next     = 1'b1;
          wait_cnt_next = '0;
        end
      end
      ST_SETUP: begin
        penable_next = 1'b1;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          // PSLVERR is only meaningful alongside PREADY.
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = pwrite_reg ? '0 : PRDATA;
          rsp_err_next     = PSLVERR;
          rsp_timeout_next = 1'b0;
        end else if (timeout_hit) begin
          psel_next        = 1'b0;
          penable_next     = 1'b0;
          rsp_valid_next   = 1'b1;
          rsp_rdata_next   = '0;
          rsp_err_next     = 1'b1;
          rsp_timeout_next = 1'b1;
        end else if (wait_cnt_reg != CNT_MAX) begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) rsp_valid_next = 1'b0;
      end
      default: ;
    endcase
  end

  assign req_ready   = (state_reg == ST_IDLE);
  assign rsp_valid   = rsp_valid_reg;
  assign rsp_rdata   = rsp_rdata_reg;
  assign rsp_err     = rsp_err_reg;
  assign rsp_timeout = rsp_timeout_reg;
  assign PADDR       = paddr_reg;
  assign PSEL        = psel_reg;
  assign PENABLE     = penable_reg;
  assign PWRITE      = pwrite_reg;
  assign PWDATA      = pwdata_reg;

endmodule
